// File: rtl/cut_char_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cut_char_pkg: shared types and helpers for the cut sweep sequencer.    |
// | Define CUT_SWEEP_GRAY_EN for Gray-code vector order.  Rev 1.0           |
// +-------------------------------------------------------------------------+
package cut_char_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic int tt_width(input int num_in);
    return 1 << num_in;
  endfunction

  // Maps sweep step i to the vector driven onto the cut.
  function automatic logic [5:0] vec_order(input logic [5:0] i);
`ifdef CUT_SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/cut_vec_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cut_vec_gen: sweep step counter and vector-order mapping.              |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module cut_vec_gen
  import cut_char_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  output logic [NUM_IN-1:0] cut_in,
  output logic              first_step,
  output logic              last_step
);

  logic [NUM_IN-1:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (load) begin
      step_d = '0;
    end else if (advance) begin
      step_d = step_q + NUM_IN'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  // The step never advances past the last one, so cut_in holds the final vector when idle.
  assign cut_in     = NUM_IN'(vec_order(6'(step_q)));
  assign first_step = (step_q == '0);
  assign last_step  = (step_q == '1);

endmodule
`default_nettype wire

// File: rtl/cut_sweep_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cut_sweep_ctrl: exhaustive sweep of a small combinational cut, building |
// | truth table, onset and toggle counts. CUT_SWEEP_GRAY_EN selects Gray.   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module cut_sweep_ctrl
  import cut_char_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_IN-1:0]               cut_in,
  input  logic                            cut_out,
  output logic [tt_width(NUM_IN)-1:0]     tt,
  output logic [NUM_IN:0]                 onset_cnt,
  output logic [NUM_IN-1:0]               toggle_cnt
);

  localparam int TT_W = tt_width(NUM_IN);

  state_e            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [NUM_IN:0]   onset_q, onset_d;
  logic [NUM_IN-1:0] toggle_q, toggle_d;
  logic              prev_q, prev_d;
  logic              load, advance, first_step, last_step;

  cut_vec_gen #(.NUM_IN(NUM_IN)) u_vec_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (advance),
    .cut_in     (cut_in),
    .first_step (first_step),
    .last_step  (last_step)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    tt_d     = tt_q;
    onset_d  = onset_q;
    toggle_d = toggle_q;
    prev_d   = prev_q;
    load     = 1'b0;
    advance  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          tt_d     = '0;
          onset_d  = '0;
          toggle_d = '0;
          wait_d   = 4'(SETTLE_CYC);
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // Abort wins over a sample due in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          tt_d[cut_in] = cut_out;
          onset_d      = onset_q + (NUM_IN+1)'(cut_out);
          if (!first_step && (cut_out != prev_q)) begin
            toggle_d = toggle_q + NUM_IN'(1);
          end
          prev_d = cut_out;
          if (last_step) begin
            state_d = ST_FIN;
          end else begin
            advance = 1'b1;
            wait_d  = 4'(SETTLE_CYC);
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      tt_q     <= '0;
      onset_q  <= '0;
      toggle_q <= '0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      tt_q     <= tt_d;
      onset_q  <= onset_d;
      toggle_q <= toggle_d;
      prev_q   <= prev_d;
    end
  end

  assign busy       = (state_q == ST_EVAL);
  assign done       = (state_q == ST_FIN);
  assign tt         = tt_q;
  assign onset_cnt  = onset_q;
  assign toggle_cnt = toggle_q;

endmodule
`default_nettype wire

// File: tb/tb_cut_sweep_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_cut_sweep_ctrl: scoreboard bench for cut_sweep_ctrl (both orders).  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_cut_sweep_ctrl;

`ifdef CUT_SWEEP_GRAY_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  on;
    logic [3:0]  tog;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, abort, start0, abort0;
  logic        busy, done, busy0, done0;
  logic [3:0]  cut_in, cut_in0;
  logic        cut_out, cut_out0;
  logic [15:0] tt, tt0;
  logic [4:0]  onset, onset0;
  logic [3:0]  tog, tog0;
  int          mode;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t q[$];
  exp_t q0[$];
  exp_t e, e0;
  int   seen[16];

  cut_sweep_ctrl #(.NUM_IN(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .cut_in(cut_in), .cut_out(cut_out), .tt(tt), .onset_cnt(onset), .toggle_cnt(tog)
  );

  cut_sweep_ctrl #(.NUM_IN(4), .SETTLE_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .cut_in(cut_in0), .cut_out(cut_out0), .tt(tt0), .onset_cnt(onset0), .toggle_cnt(tog0)
  );

  always_comb begin
    case (mode)
      0:       cut_out = ^cut_in;
      1:       cut_out = &cut_in;
      2:       cut_out = cut_in[0];
      3:       cut_out = |cut_in;
      default: cut_out = 1'b0;
    endcase
  end
  assign cut_out0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the SETTLE_CYC=1 instance.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("tt", 32'(tt), 32'(e.tt));
        check("onset", 32'(onset), 32'(e.on));
        check("toggle", 32'(tog), 32'(e.tog));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Monitor for the SETTLE_CYC=0 instance, including vector coverage.
  always @(negedge clk) begin
    if (busy0 === 1'b1) seen[cut_in0] = seen[cut_in0] + 1;
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("unexpected_done0", 32'd1, 32'd0);
      end else begin
        logic [15:0] cov;
        e0 = q0.pop_front();
        cov = '0;
        for (int k = 0; k < 16; k++) cov[k] = (seen[k] == 1);
        check("tt0", 32'(tt0), 32'(e0.tt));
        check("onset0", 32'(onset0), 32'(e0.on));
        check("toggle0", 32'(tog0), 32'(e0.tog));
        check("done_cycle0", 32'(cyc), 32'(e0.cyc));
        check("cut_in_cover0", 32'(cov), 32'hFFFF);
      end
      for (int k = 0; k < 16; k++) seen[k] = 0;
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || q0.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q0.size() != 0) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
      q.delete();
      q0.delete();
    end
    @(negedge clk);
  endtask

  task automatic sweep(input int m, input logic [15:0] ett, input logic [4:0] eon,
                       input logic [3:0] etog_bin, input logic [3:0] etog_gray, input string name);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    q.push_back('{tt: ett, on: eon, tog: (GRAY ? etog_gray : etog_bin), cyc: cyc + 33});
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    drain(name);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_cut_in"}, 32'(cut_in), 32'd0);
    check({name, "_tt"}, 32'(tt), 32'd0);
    check({name, "_onset"}, 32'(onset), 32'd0);
    check({name, "_toggle"}, 32'(tog), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) seen[k] = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0; mode = 0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    sweep(0, 16'h6996, 5'd8,  4'd10, 4'd15, "xor");
    sweep(1, 16'h8000, 5'd1,  4'd1,  4'd2,  "and");
    sweep(2, 16'hAAAA, 5'd8,  4'd15, 4'd8,  "bit0");
    sweep(3, 16'hFFFE, 5'd15, 4'd1,  4'd1,  "or");

    // Constant-zero cut on the zero-settle instance.
    @(negedge clk);
    start0 = 1'b1;
    q0.push_back('{tt: 16'h0, on: 5'd0, tog: 4'd0, cyc: cyc + 17});
    @(negedge clk);
    start0 = 1'b0;
    drain("zero");

    // Abort in cycle 10 with start re-pulsed; abort beats the vector-4 sample.
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_tt", 32'(tt), 32'h0006);
    check("abort_onset", 32'(onset), 32'd2);
    check("abort_toggle", 32'(tog), GRAY ? 32'd3 : 32'd2);
    check("abort_cut_in", 32'(cut_in), GRAY ? 32'd6 : 32'd4);
    q.push_back('{tt: 16'h6996, on: 5'd8, tog: (GRAY ? 4'd15 : 4'd10), cyc: cyc + 33});
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    drain("after_abort");

    // Asynchronous reset mid-sweep.
    @(negedge clk);
    mode  = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    sweep(1, 16'h8000, 5'd1, 4'd1, 4'd2, "after_rst");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cut_sweep_ctrl.md
Name: cut_sweep_ctrl

Overview:
Sequencer that exhaustively exercises one small combinational logic cut, such as a 4-input, 1-output rewrite sub-circuit, for power and equivalence characterisation.
- On start, it drives every input vector onto the cut in a fixed order and waits a programmable settle time per vector.
- It samples the cut output and builds the full truth table, onset count and output toggle count.
- It sits between the characterisation harness (start/done handshake) and the cut under test (cut_in/cut_out).

Parameters:
NUM_IN, 4, number of cut inputs; TT_W = 2**NUM_IN truth-table bits; legal range 1..6.
SETTLE_CYC, 1, wait cycles after driving a vector before sampling; 0 = sample in the cycle the vector is driven; legal range 0..15.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request a sweep; accepted only in IDLE.
abort  in  1  synchronous abort of a running sweep.
busy  out  1  high while a sweep is in progress.
done  out  1  one-cycle pulse when results become valid.
cut_in  out  NUM_IN  vector driven to the cut under test.
cut_out  in  1  cut response.
tt  out  TT_W  truth table; bit k = cut_out sampled while cut_in == k.
onset_cnt  out  NUM_IN+1  number of 1 bits in tt.
toggle_cnt  out  NUM_IN  number of cut_out changes between consecutive vectors in sweep order (max TT_W-1).

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, cut_in=0, tt=0, onset_cnt=0, toggle_cnt=0, internal counters 0.
- FSM states: IDLE, EVAL, FIN.
  - IDLE + start=1: clear tt, onset_cnt, toggle_cnt; next cycle go to EVAL with step=0, cut_in=order(0), wait=SETTLE_CYC, busy=1.
  - EVAL, wait>0: decrement wait; cut_in held stable.
  - EVAL, wait==0: sample cut_out into tt[cut_in] and add it to onset_cnt.
    - If step>0 and cut_out != previous sample: toggle_cnt+1.
    - Store the sample as the previous sample.
    - If step==TT_W-1, go to FIN.
    - Otherwise step+1, cut_in=order(step+1), wait=SETTLE_CYC.
  - FIN: done=1 for exactly one cycle, busy=0; next state IDLE.
- Latency: start sampled at cycle 0 → done high at cycle 1 + TT_W*(SETTLE_CYC+1). Defaults give 33.
- Results are held stable from done until the next accepted start; cut_in holds the last vector while IDLE.
- start while busy or in FIN: ignored, no queuing.
- abort=1 in EVAL: go to IDLE next cycle; busy=0, no done, partial results retained but not valid.
  - abort has priority over sampling in the same cycle.
  - abort in IDLE or FIN: ignored.
- start and abort both high in IDLE: start wins.
- rst mid-sweep: immediate return to reset values; no done.
- order(i) = i (binary order) unless the optional feature is enabled.
- Counters use no wrap: onset_cnt max TT_W, toggle_cnt max TT_W-1; widths are sized for these maxima.

Optional Feature:
CUT_SWEEP_GRAY_EN
- Defined: order(i) = i ^ (i>>1) (Gray order), so exactly one input bit changes per step. This is the realistic low-activity stimulus for power estimation. tt is still indexed by the actual cut_in value.
- Undefined: binary order.
- tt and onset_cnt are identical in both modes; only toggle_cnt differs.

Decomposition:
- Shared package cut_char_pkg holds:
  - FSM state enum (IDLE/EVAL/FIN);
  - localparam function tt_width(NUM_IN);
  - vector-order function (binary/Gray).
- One natural sub-module: cut_vec_gen, the step counter plus order mapping, producing cut_in and a last_step flag.

Test Plan:
1. Defaults, cut_out = ^cut_in (XOR of all inputs), binary order → done at cycle 33; tt=0x6996, onset_cnt=8, toggle_cnt=10.
2. Same XOR cut with CUT_SWEEP_GRAY_EN → tt=0x6996, onset_cnt=8, toggle_cnt=15.
3. cut_out = &cut_in (AND of all inputs) → tt=0x8000, onset_cnt=1; toggle_cnt=1 in binary order, 2 in Gray order.
4. cut_out tied to 0, SETTLE_CYC=0 → done at cycle 17; tt=0, onset_cnt=0, toggle_cnt=0. Also check cut_in covers 0..15 once each.
5. abort at cycle 10 with start re-pulsed on the same cycle → no done; busy falls next cycle; start accepted only after IDLE; second sweep gives correct results.
6. rst asserted asynchronously mid-EVAL → all outputs 0 immediately; after release a new start completes normally.
